count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
- Sequencing controller for the team's mod-2^WIDTH up/down counter datapath.
- Accepts a target value over a valid/ready command port and chooses the count direction (select line: 0 = up, 1 = down).
- Steps the counter one LSB per prescaled tick until it equals the target, then pulses done.
- Sits between a host/command source and the counter; exposes the live count.

Parameters:
- WIDTH, 4, counter and target width in bits (>=2).
- PRESCALE, 1, clock cycles per count step (>=1); each step is one tick.

Ports:
- clk  input  1  sole clock, rising edge.
- rest  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_target  input  WIDTH  requested final count; sampled on acceptance.
- abort  input  1  cancel the run in progress.
- cnt_q  output  WIDTH  current counter value.
- dir  output  1  direction select driven to the counter: 0 = up, 1 = down.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset (rest=1, async): state IDLE, cnt_q=0, dir=0, busy=0, done=0, internal tick=0. cmd_ready=1 once in IDLE.
- States:
  - IDLE: cmd_ready=1. Acceptance occurs on a clock edge with cmd_valid&cmd_ready. On acceptance, the controller latches the target and clears tick.
    - If target==cnt_q, go to DONE.
    - Otherwise go to RUN with dir=0 if target>cnt_q, else dir=1 (unsigned compare, no wrap).
  - RUN: busy=1, cmd_ready=0. tick counts 0..PRESCALE-1.
    - On an edge where tick==PRESCALE-1, cnt_q steps +1 (dir=0) or -1 (dir=1) and tick returns to 0.
    - If the stepped value equals the target, go to DONE at the same edge.
  - DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0. Next state is IDLE.
- Latency:
  - Distance D>0 steps: the last step lands at edge accept+D*PRESCALE, and done is high the following cycle.
  - D=0: done is high the cycle after acceptance.
- dir is held constant for the whole run. It changes only on acceptance or reset.
- cnt_q holds in IDLE and DONE. It never changes except by a step or by reset.
- abort:
  - In RUN: return to IDLE on the next edge with no step that edge (abort beats a coincident step). cnt_q keeps its partial value and done is not pulsed.
  - In IDLE or DONE: ignored.
- cmd_valid while not ready: the command is not consumed and the source must hold it. A command presented in the DONE cycle is accepted one cycle later, in IDLE.
- rest asserted mid-run: immediate return to reset values; the in-flight target is discarded.
- Arithmetic is modulo 2^WIDTH. Wrap is reachable only with WRAP_SHORTEST_EN.

Optional Feature:
- Macro COUNT_CTRL_WRAP_SHORTEST_EN.
- Defined: direction is chosen by the shortest modular path. up_dist = (target-cnt_q) mod 2^WIDTH and down_dist = 2^WIDTH-up_dist.
  - dir=0 if up_dist<=down_dist (a tie goes up); otherwise dir=1.
  - The counter may wrap through 0 or through 2^WIDTH-1.
- Undefined: plain magnitude compare as above; no step ever wraps.

Decomposition:
- Package count_ctrl_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - helper function for modular distance, used only under the macro.
- Sub-module updown_cnt:
  - WIDTH-bit register with async active-high rest, enable, and dir;
  - outputs q, with q+1 when dir=0 and q-1 when dir=1 on enable.
  - count_ctrl instantiates one and owns the FSM and the prescale tick.

Test Plan:
- Reset then command target=9, PRESCALE=1, from cnt_q=0 -> dir=0; cnt_q 1..9 on 9 consecutive edges; done high one cycle after 9; cmd_ready=1 the next cycle.
- From 9, target=3, PRESCALE=3 -> dir=1; cnt_q decrements every 3rd cycle; 6 steps in 18 cycles; then a done pulse.
- Target equal to cnt_q=3 -> done pulse the cycle after acceptance; cnt_q unchanged; busy never high.
- Run 3->12, abort asserted when cnt_q=7 on a step edge -> cnt_q stays 7, no done, IDLE with cmd_ready=1; a new target=5 runs down.
- rest pulsed mid-run (cnt_q=6) -> cnt_q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- With COUNT_CTRL_WRAP_SHORTEST_EN, from 14 to target=1 -> dir=0, sequence 15,0,1, done.
  - Tie case 0->8 -> dir=0.
  - Without the macro, 14->1 -> dir=1, 13 steps down.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_ctrl_pkg
//  Description : Shared types and constants for the count_ctrl sequencer:
//                FSM state encoding, direction-select codes and a modular
//                distance helper used by the shortest-path direction option.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Upward distance from from_val to to_val, modulo 2^width.
   function automatic logic [31:0] mod_up_dist(input logic [31:0] from_val,
                                               input logic [31:0] to_val,
                                               input int unsigned width);
      logic [31:0] mask;
      mask = (32'd1 << width) - 32'd1;
      return (to_val - from_val) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/updown_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : updown_cnt
//  Description : WIDTH-bit modular up/down counter. Steps by one LSB on each
//                enabled edge: up when dir=0, down when dir=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_cnt
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // Counter register; wraps naturally modulo 2^WIDTH.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         r_q <= '0;
      end else if (en) begin
         if (dir == DIR_DOWN) begin
            r_q <= r_q - WIDTH'(1);
         end else begin
            r_q <= r_q + WIDTH'(1);
         end
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_ctrl
//  Description : Sequencing controller for the up/down counter datapath.
//                Accepts a target over a valid/ready port, selects the count
//                direction, steps the counter once per PRESCALE cycles until
//                it reaches the target, then pulses done for one cycle.
//                Optional macro COUNT_CTRL_WRAP_SHORTEST_EN selects the
//                shortest modular path (ties go up) instead of a plain
//                magnitude compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             abort,
   output logic [WIDTH-1:0] cnt_q,
   output logic             dir,
   output logic             busy,
   output logic             done
);

   localparam int c_tick_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(PRESCALE - 1);

   state_t              r_state;
   logic [WIDTH-1:0]    r_target;
   logic [c_tick_w-1:0] r_tick;
   logic                r_dir;
   logic                r_busy;
   logic                r_done;
   logic                r_ready;

   logic [WIDTH-1:0]    w_cnt;
   logic [WIDTH-1:0]    w_next;
   logic                w_last_tick;
   logic                w_step;
   logic                w_dir_sel;

   // A step happens on the last prescale tick of RUN unless abort wins.
   assign w_last_tick = (r_tick == c_tick_last);
   assign w_step      = (r_state == ST_RUN) && w_last_tick && !abort;
   assign w_next      = (r_dir == DIR_DOWN) ? (w_cnt - WIDTH'(1)) : (w_cnt + WIDTH'(1));

`ifdef COUNT_CTRL_WRAP_SHORTEST_EN
   logic [31:0] w_up_dist;

   // Up wins when up_dist <= 2^WIDTH - up_dist, i.e. up_dist <= 2^(WIDTH-1).
   assign w_up_dist = mod_up_dist(32'(w_cnt), 32'(cmd_target), WIDTH);
   assign w_dir_sel = (w_up_dist <= (32'd1 << (WIDTH - 1))) ? DIR_UP : DIR_DOWN;
`else
   // Plain unsigned magnitude compare: the run never wraps.
   assign w_dir_sel = (cmd_target > w_cnt) ? DIR_UP : DIR_DOWN;
`endif

   updown_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rest (rest),
      .en   (w_step),
      .dir  (r_dir),
      .q    (w_cnt)
   );

   // Control FSM with registered handshake/status outputs and prescale tick.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         r_state  <= ST_IDLE;
         r_target <= '0;
         r_tick   <= '0;
         r_dir    <= DIR_UP;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (cmd_valid) begin
                  r_target <= cmd_target;
                  r_tick   <= '0;
                  r_ready  <= 1'b0;
                  if (cmd_target == w_cnt) begin
                     // Nothing to count: dir is left as it was.
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                     r_dir   <= w_dir_sel;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_tick  <= '0;
               end else if (w_last_tick) begin
                  r_tick <= '0;
                  if (w_next == r_target) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_tick <= r_tick + c_tick_w'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign cnt_q     = w_cnt;
   assign dir       = r_dir;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_ctrl
//  Description : Self-checking bench for count_ctrl. Two instances (PRESCALE
//                1 and 3) are driven by a vector table, a reset-mid-run
//                sequence and random commands, each checked cycle by cycle
//                against an arithmetic model of the expected trajectory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_ctrl;

   localparam int W    = 4;
   localparam int MODV = 16;

   logic           clk;
   logic           rest;
   logic [1:0]     cmd_valid;
   logic [1:0]     cmd_ready;
   logic [W-1:0]   cmd_target [2];
   logic [1:0]     abort;
   logic [W-1:0]   cnt_q [2];
   logic [1:0]     dir;
   logic [1:0]     busy;
   logic [1:0]     done;

   int  checks;
   int  errors;

   int  m_cnt [2];
   int  m_dir [2];
   bit  m_dir_known [2];
   time m_done_t [2];

   count_ctrl #(.WIDTH(W), .PRESCALE(1)) u_dut_p1 (
      .clk(clk), .rest(rest), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_target(cmd_target[0]), .abort(abort[0]), .cnt_q(cnt_q[0]),
      .dir(dir[0]), .busy(busy[0]), .done(done[0]));

   count_ctrl #(.WIDTH(W), .PRESCALE(3)) u_dut_p3 (
      .clk(clk), .rest(rest), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_target(cmd_target[1]), .abort(abort[1]), .cnt_q(cnt_q[1]),
      .dir(dir[1]), .busy(busy[1]), .done(done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wrapv(input int x);
      return ((x % MODV) + MODV) % MODV;
   endfunction

   function automatic int presc(input int sel);
      return (sel != 0) ? 3 : 1;
   endfunction

   // Direction rule straight from the behavioural description.
   function automatic int dir_rule(input int start, input int tgt);
`ifdef COUNT_CTRL_WRAP_SHORTEST_EN
      int up;
      up = wrapv(tgt - start);
      return (up <= MODV - up) ? 0 : 1;
`else
      return (tgt > start) ? 0 : 1;
`endif
   endfunction

   function automatic int dist_of(input int start, input int tgt);
      if (tgt == start) return 0;
      return (dir_rule(start, tgt) != 0) ? wrapv(start - tgt) : wrapv(tgt - start);
   endfunction

   task automatic check(input int sel, input string name, input int e_cnt, input int e_dir,
                        input int e_busy, input int e_done, input int e_ready, input bit dir_care);
      logic [W+3:0] act;
      logic [W+3:0] expv;
      act  = {cnt_q[sel], dir_care ? dir[sel] : 1'b0, busy[sel], done[sel], cmd_ready[sel]};
      expv = {W'(e_cnt), dir_care ? e_dir[0] : 1'b0, e_busy[0], e_done[0], e_ready[0]};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got cnt=%0d dir=%b busy=%b done=%b rdy=%b, want cnt=%0d dir=%0d busy=%0d done=%0d rdy=%0d",
                  name, sel, $time, cnt_q[sel], dir[sel], busy[sel], done[sel], cmd_ready[sel],
                  e_cnt, e_dir, e_busy, e_done, e_ready);
      end
   endtask

   // Issue one command and follow it. Called and returns at a negedge.
   // abort_k: edge index after acceptance carrying abort (0 = none).
   // stop_k : return early after this RUN sample (-1 = run to the end).
   task automatic run_cmd(input int sel, input int tgt, input int abort_k,
                          input int stop_k, input bit idle_abort);
      int start, p, d, ed, sgn, total, e;
      bit dk;
      p     = presc(sel);
      start = m_cnt[sel];
      d     = dist_of(start, tgt);
      if (d == 0) begin
         ed = m_dir[sel];
         dk = m_dir_known[sel];
      end else begin
         ed = dir_rule(start, tgt);
         dk = 1'b1;
      end
      sgn   = (ed != 0) ? -1 : 1;
      total = d * p;

      cmd_valid[sel]  = 1'b1;
      cmd_target[sel] = W'(tgt);
      abort[sel]      = idle_abort;
      if (m_done_t[sel] == $time) begin
         // DONE cycle: command must be held and taken one cycle later.
         @(negedge clk);
         check(sel, "done_to_idle", start, m_dir[sel], 0, 0, 1, m_dir_known[sel]);
      end
      @(negedge clk);
      cmd_valid[sel]  = 1'b0;
      cmd_target[sel] = W'($urandom);
      abort[sel]      = 1'b0;

      for (int k = 0; k <= total; k++) begin
         if (abort_k > 0 && k == abort_k) begin
            e = wrapv(start + sgn * ((k - 1) / p));
            check(sel, "abort_idle", e, ed, 0, 0, 1, dk);
            m_cnt[sel] = e; m_dir[sel] = ed; m_dir_known[sel] = dk;
            return;
         end
         if (k == total) begin
            check(sel, "done_pulse", tgt, ed, 0, 1, 0, dk);
            m_cnt[sel] = tgt; m_dir[sel] = ed; m_dir_known[sel] = dk;
            m_done_t[sel] = $time;
            return;
         end
         e = wrapv(start + sgn * (k / p));
         check(sel, "run_step", e, ed, 1, 0, 0, dk);
         if (k == stop_k) begin
            m_cnt[sel] = e; m_dir[sel] = ed; m_dir_known[sel] = dk;
            return;
         end
         if (abort_k > 0 && k + 1 == abort_k) abort[sel] = 1'b1;
         @(negedge clk);
         abort[sel] = 1'b0;
      end
   endtask

   typedef struct {
      int sel;
      int tgt;
      int abort_k;
      bit idle_abort;
      int exp_dir;    // -1: not checked
      int exp_final;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t, want finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rest = 1'b1;
      cmd_valid = '0;
      abort = '0;
      for (int s = 0; s < 2; s++) begin
         cmd_target[s] = '0;
         m_cnt[s] = 0; m_dir[s] = 0; m_dir_known[s] = 1'b1; m_done_t[s] = 0;
      end

      //              sel tgt ab  ia  dir  final
      tbl[0]  = '{0,  9,  0, 0,  0,   9};
`ifdef COUNT_CTRL_WRAP_SHORTEST_EN
      tbl[1]  = '{0,  0,  0, 0,  0,   0};
`else
      tbl[1]  = '{0,  0,  0, 0,  1,   0};
`endif
      tbl[2]  = '{0,  8,  0, 0,  0,   8};
      tbl[3]  = '{1,  6,  0, 0,  0,   6};
      tbl[4]  = '{1,  9,  0, 0,  0,   9};
      tbl[5]  = '{1,  3,  0, 0,  1,   3};
      tbl[6]  = '{1,  3,  0, 1, -1,   3};
`ifdef COUNT_CTRL_WRAP_SHORTEST_EN
      tbl[7]  = '{1, 12, 15, 0,  1,  15};
      tbl[8]  = '{1,  5,  0, 0,  0,   5};
`else
      tbl[7]  = '{1, 12, 15, 0,  0,   7};
      tbl[8]  = '{1,  5,  0, 0,  1,   5};
`endif
      tbl[9]  = '{0, 14,  0, 0,  0,  14};
`ifdef COUNT_CTRL_WRAP_SHORTEST_EN
      tbl[10] = '{0,  1,  0, 1,  0,   1};
`else
      tbl[10] = '{0,  1,  0, 1,  1,   1};
`endif

      repeat (2) @(negedge clk);
      check(0, "reset_state", 0, 0, 0, 0, 1, 1'b1);
      check(1, "reset_state", 0, 0, 0, 0, 1, 1'b1);
      rest = 1'b0;
      @(negedge clk);
      check(0, "idle_after_reset", 0, 0, 0, 0, 1, 1'b1);

      for (int i = 0; i < 11; i++) begin
         run_cmd(tbl[i].sel, tbl[i].tgt, tbl[i].abort_k, -1, tbl[i].idle_abort);
         if (tbl[i].exp_dir >= 0) begin
            checks++;
            if (dir[tbl[i].sel] !== tbl[i].exp_dir[0]) begin
               errors++;
               $display("FAIL vec%0d_dir: got %b, want %0d", i, dir[tbl[i].sel], tbl[i].exp_dir);
            end
         end
         checks++;
         if (cnt_q[tbl[i].sel] !== W'(tbl[i].exp_final)) begin
            errors++;
            $display("FAIL vec%0d_final: got %0d, want %0d", i, cnt_q[tbl[i].sel], tbl[i].exp_final);
         end
      end

      // Reset mid-run: reach cnt_q=6 on the PRESCALE=3 instance, then reset
      // between edges and observe the outputs before any further edge.
      run_cmd(1, 0, 0, -1, 1'b0);
      run_cmd(1, 7, 0, 18, 1'b0);
      #2;
      rest = 1'b1;
      #1;
      check(1, "async_reset_midrun", 0, 0, 0, 0, 1, 1'b1);
      check(0, "async_reset_idle", 0, 0, 0, 0, 1, 1'b1);
      @(negedge clk);
      rest = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_cnt[s] = 0; m_dir[s] = 0; m_dir_known[s] = 1'b1; m_done_t[s] = 0;
      end
      @(negedge clk);
      check(1, "idle_after_midrun_reset", 0, 0, 0, 0, 1, 1'b1);

      // Random commands, aborts and idle gaps.
      for (int i = 0; i < 60; i++) begin
         int sel, tgt, d, ak;
         sel = $urandom_range(0, 1);
         tgt = $urandom_range(0, MODV - 1);
         d   = dist_of(m_cnt[sel], tgt);
         ak  = 0;
         if (d > 0 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, d * presc(sel));
         run_cmd(sel, tgt, ak, -1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
